sid_multi_voice_mixer: RTL and testbench
========================================

# sid_multi_voice_mixer

Parametrised register bank and sequential mixer for an N-voice SID synthesizer; it generalises the fixed dual-voice front end. It decodes edge-triggered writes from the pin-level register interface into per-voice register banks. It applies per-voice gain and mute, then accumulates the voices one per clock into a saturated 8-bit sample for the PWM audio stage. The `sid_voice` instances and `pwm_audio` remain outside the block.

## Interface
- `NUM_VOICES`, 4: number of voices, legal 2..8.
- `VSEL_W`, 2: voice-select width; must satisfy 2^VSEL_W >= NUM_VOICES.
- `MIX_SHIFT`, 2: right shift applied to the accumulated sum, legal 0..3.
- `SAMPLE_DIV`, 255: clocks per output sample; must be >= NUM_VOICES+2.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `reg_addr` in 3: register address.
- `voice_sel` in VSEL_W: target voice.
- `wr_en` in 1: write strobe; acts on its rising edge.
- `wr_data` in 8: write data.
- `voice_in` in 8*NUM_VOICES: voice outputs; voice k is `[8k+7:8k]`.
- `frequency` out 16*NUM_VOICES: per-voice frequency.
- `duration`, `attack`, `sustain`, `waveform` out 8*NUM_VOICES each: per-voice registers.
- `mix_out` out 8: current mixed sample.
- `sample_valid` out 1: one-cycle pulse when `mix_out` updates.

## Operation
- Write detect: `wr_en_d` registers `wr_en`. A write occurs in a cycle where `wr_en`=1 and `wr_en_d`=0. A held `wr_en` writes exactly once.
- Writes with `voice_sel` >= NUM_VOICES are ignored.
- Per-voice address map:
  - 0: freq[7:0]
  - 1: freq[15:8]
  - 2: duration
  - 3: gain
  - 4: attack
  - 5: sustain
  - 6: waveform
  - 7: ctrl (bit0 = mute, bits 7:1 ignored)
- Gain and ctrl are internal; they are not ported out.
- Reset values: every port register = 0, gain = 0xFF, mute = 0, `mix_out` = 0, `sample_valid` = 0, `wr_en_d` = 0, divider = 0, accumulator = 0, idx = 0.
- Term for voice k: term_k = mute_k ? 0 : (voice_in_k * (gain_k + 1)) >> 8, giving 8 bits.
  - gain 0xFF passes the input unchanged.
  - gain 0x7F halves it.
  - gain 0x00 gives voice_in >> 8 = 0.
- Divider `div_cnt` counts 0..SAMPLE_DIV-1 and wraps.
- Scan FSM:
  - IDLE: at the edge ending a cycle with `div_cnt`==0, acc <= term_0, idx <= 1, go to ACC. If NUM_VOICES were 1 it would finalise here, but 1 is not legal.
  - ACC: each edge does acc <= acc + term_idx and idx++.
  - At the edge where idx == NUM_VOICES-1: `mix_out` <= sat8((acc + term_idx) >> MIX_SHIFT), `sample_valid` <= 1, go to IDLE.
- Accumulator width: 8 + ceil(log2(NUM_VOICES)) bits. It never overflows internally.
- sat8 clamps to 255 any value above 255. With MIX_SHIFT < log2(NUM_VOICES), saturation is reachable and required.
- Register and gain changes mid-scan take effect for any voice not yet accumulated. The gain in force at that voice's accumulation edge is used.

## Timing
- Register write latency: the register updates at the edge ending the rising-edge cycle and is visible on ports the next cycle.
- Voice k is sampled at the edge ending the cycle with `div_cnt`==k.
- `mix_out` changes at the edge ending the cycle with `div_cnt`==NUM_VOICES-1.
- `sample_valid` is high exactly during the cycle with `div_cnt`==NUM_VOICES, once per SAMPLE_DIV clocks.
- `mix_out` holds its value between updates.
- Reset asserted mid-scan:
  - next cycle, all state equals the reset values;
  - the partial sum is discarded and no `sample_valid` is issued;
  - after release, the first cycle has `div_cnt`=0.
- `wr_en` high while `rst` is high: `wr_en_d` is forced to 0 during reset. If `wr_en` is still high in the first cycle after reset, it counts as a rising edge and writes.

## Test plan
- Reset, then hold `wr_en`=1 for 5 cycles with addr 0, voice 1, data 0x34 → voice-1 frequency = 0x0034 after one write. Then change data to 0x99 while `wr_en` is still held → no second write.
- Write addr 1 data 0x12 and addr 0 data 0x34 to voice 2; write addr 6 data 0x41 with `voice_sel`=3 and NUM_VOICES=3 → voice-2 freq = 0x1234; no register changes for the out-of-range write.
- NUM_VOICES=4, MIX_SHIFT=2, all `voice_in`=0xFF, gains at reset → `mix_out`=0xFF, `sample_valid` pulses at `div_cnt`=4, period 255 clocks.
- Same setup with MIX_SHIFT=0 → sum 1020 clamps to `mix_out`=0xFF. Then set voices 1..3 mute=1 and voice 0 = 0x80 → next sample = 0x80.
- Gain 0x7F on voice 0, `voice_in0`=0xC8, other voices 0, MIX_SHIFT=0 → `mix_out`=0x64.
- Assert `rst` at `div_cnt`=2 for one cycle → `mix_out`=0 and no `sample_valid` until the next full scan completes, at `div_cnt`=4 relative to release.

Source files
------------

// File: rtl/sid_multi_voice_mixer.sv
// N-voice SID register bank and sequential mixer: decodes rising-edge register
// writes per voice, then scales, mutes and sums one voice per clock into an 8-bit sample.
module sid_multi_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int VSEL_W     = 2,
  parameter int MIX_SHIFT  = 2,
  parameter int SAMPLE_DIV = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              reg_addr,
  input  logic [VSEL_W-1:0]       voice_sel,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  input  logic [8*NUM_VOICES-1:0] voice_in,
  output logic [16*NUM_VOICES-1:0] frequency,
  output logic [8*NUM_VOICES-1:0] duration,
  output logic [8*NUM_VOICES-1:0] attack,
  output logic [8*NUM_VOICES-1:0] sustain,
  output logic [8*NUM_VOICES-1:0] waveform,
  output logic [7:0]              mix_out,
  output logic                    sample_valid
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = 8 + $clog2(NUM_VOICES);
  localparam int DIV_W = $clog2(SAMPLE_DIV);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } scan_state_t;

  scan_state_t state, state_next;

  logic [7:0]            gain [NUM_VOICES];
  logic [NUM_VOICES-1:0] mute;
  logic                  wr_en_d;
  logic                  wr_fire;
  logic [DIV_W-1:0]      div_cnt;
  logic [ACC_W-1:0]      acc;
  logic [IDX_W-1:0]      idx;
  logic                  last_voice;

  logic [7:0]       cur_voice;
  logic [7:0]       cur_gain;
  logic             cur_mute;
  logic [7:0]       term;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] shifted;
  logic [7:0]       sat;

  // A held strobe writes once: only the first cycle of a high wr_en counts.
  assign wr_fire = wr_en & ~wr_en_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_d   <= 1'b0;
      frequency <= '0;
      duration  <= '0;
      attack    <= '0;
      sustain   <= '0;
      waveform  <= '0;
      mute      <= '0;
      for (int k = 0; k < NUM_VOICES; k++) begin
        gain[k] <= 8'hFF;
      end
    end else begin
      wr_en_d <= wr_en;
      for (int k = 0; k < NUM_VOICES; k++) begin
        if (wr_fire && (voice_sel == VSEL_W'(k))) begin
          case (reg_addr)
            3'd0:    frequency[16*k +: 8]   <= wr_data;
            3'd1:    frequency[16*k+8 +: 8] <= wr_data;
            3'd2:    duration[8*k +: 8]     <= wr_data;
            3'd3:    gain[k]                <= wr_data;
            3'd4:    attack[8*k +: 8]       <= wr_data;
            3'd5:    sustain[8*k +: 8]      <= wr_data;
            3'd6:    waveform[8*k +: 8]     <= wr_data;
            default: mute[k]                <= wr_data[0];
          endcase
        end
      end
    end
  end

  // idx is 0 while idle, so the same mux feeds the first term and the later ones.
  always_comb begin
    cur_voice = '0;
    cur_gain  = '0;
    cur_mute  = 1'b0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_voice = voice_in[8*k +: 8];
        cur_gain  = gain[k];
        cur_mute  = mute[k];
      end
    end
    term = cur_mute ? 8'd0
                    : 8'((16'(cur_voice) * (16'(cur_gain) + 16'd1)) >> 8);
  end

  assign acc_sum = acc + ACC_W'(term);
  assign shifted = acc_sum >> MIX_SHIFT;
  assign sat     = (|shifted[ACC_W-1:8]) ? 8'hFF : shifted[7:0];

  always_comb begin
    state_next = state;
    last_voice = 1'b0;
    case (state)
      S_IDLE: begin
        if (div_cnt == '0) state_next = S_ACC;
      end
      S_ACC: begin
        if (idx == IDX_W'(NUM_VOICES - 1)) begin
          state_next = S_IDLE;
          last_voice = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      acc          <= '0;
      idx          <= '0;
      mix_out      <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_next;
      div_cnt      <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      sample_valid <= last_voice;
      if (state == S_IDLE) begin
        if (div_cnt == '0) begin
          acc <= ACC_W'(term);
          idx <= IDX_W'(1);
        end
      end else if (last_voice) begin
        mix_out <= sat;
        idx     <= '0;
      end else begin
        acc <= acc_sum;
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sid_multi_voice_mixer.sv
// Bench for sid_multi_voice_mixer: three configurations share one stimulus stream and
// are compared every cycle against a cycle-count model of the register bank and mixer.
module tb_sid_multi_voice_mixer;

  localparam int ND = 3;

  // d0: 4 voices, shift 2, div 255; d1: 4 voices, shift 0, div 8; d2: 3 voices, shift 0, div 8
  function automatic int p_n(input int d);
    return (d == 2) ? 3 : 4;
  endfunction
  function automatic int p_shift(input int d);
    return (d == 0) ? 2 : 0;
  endfunction
  function automatic int p_div(input int d);
    return (d == 0) ? 255 : 8;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  reg_addr;
  logic [1:0]  voice_sel;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [31:0] voice_in;

  logic [63:0] f0, f1;
  logic [31:0] du0, at0, su0, wf0, du1, at1, su1, wf1;
  logic [47:0] f2;
  logic [23:0] du2, at2, su2, wf2;
  logic [7:0]  mx0, mx1, mx2;
  logic        sv0, sv1, sv2;

  int n_checks = 0;
  int n_fail   = 0;
  logic check_en;

  always #5 clk = ~clk;

  sid_multi_voice_mixer #(.NUM_VOICES(4), .VSEL_W(2), .MIX_SHIFT(2), .SAMPLE_DIV(255)) u_d0 (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .voice_sel(voice_sel), .wr_en(wr_en),
    .wr_data(wr_data), .voice_in(voice_in), .frequency(f0), .duration(du0), .attack(at0),
    .sustain(su0), .waveform(wf0), .mix_out(mx0), .sample_valid(sv0));

  sid_multi_voice_mixer #(.NUM_VOICES(4), .VSEL_W(2), .MIX_SHIFT(0), .SAMPLE_DIV(8)) u_d1 (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .voice_sel(voice_sel), .wr_en(wr_en),
    .wr_data(wr_data), .voice_in(voice_in), .frequency(f1), .duration(du1), .attack(at1),
    .sustain(su1), .waveform(wf1), .mix_out(mx1), .sample_valid(sv1));

  sid_multi_voice_mixer #(.NUM_VOICES(3), .VSEL_W(2), .MIX_SHIFT(0), .SAMPLE_DIV(8)) u_d2 (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .voice_sel(voice_sel), .wr_en(wr_en),
    .wr_data(wr_data), .voice_in(voice_in[23:0]), .frequency(f2), .duration(du2), .attack(at2),
    .sustain(su2), .waveform(wf2), .mix_out(mx2), .sample_valid(sv2));

  // ---------------- model: register file per voice (addr 3 = gain, 7 = ctrl) ----------------
  logic [7:0] m_reg [ND][8][8];
  int         m_cnt [ND];
  int         m_part [ND];
  logic [7:0] m_mix [ND];
  logic       m_valid [ND];
  logic       m_prev_wr;

  function automatic int voice_term(input int d, input int v);
    int vin;
    int g;
    vin = int'(voice_in[8*v +: 8]);
    g   = int'(m_reg[d][v][3]);
    if (m_reg[d][v][7][0]) return 0;
    return (vin * (g + 1)) / 256;
  endfunction

  function automatic logic [7:0] sat8(input int x);
    return (x > 255) ? 8'hFF : 8'(x);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        for (int v = 0; v < 8; v++)
          for (int a = 0; a < 8; a++)
            m_reg[d][v][a] = (a == 3) ? 8'hFF : 8'h00;
        m_cnt[d]   = 0;
        m_part[d]  = 0;
        m_mix[d]   = 8'h00;
        m_valid[d] = 1'b0;
      end else begin
        int p;
        p = m_cnt[d] % p_div(d);
        m_valid[d] = 1'b0;
        if (p < p_n(d)) begin
          m_part[d] = ((p == 0) ? 0 : m_part[d]) + voice_term(d, p);
          if (p == p_n(d) - 1) begin
            m_mix[d]   = sat8(m_part[d] >> p_shift(d));
            m_valid[d] = 1'b1;
          end
        end
        if (wr_en && !m_prev_wr && (int'(voice_sel) < p_n(d)))
          m_reg[d][voice_sel][reg_addr] = wr_data;
        m_cnt[d]++;
      end
    end
    m_prev_wr = rst ? 1'b0 : wr_en;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic [127:0] f, input logic [63:0] du,
                           input logic [63:0] at, input logic [63:0] su, input logic [63:0] wf,
                           input logic [7:0] mx, input logic sv);
    for (int v = 0; v < p_n(d); v++) begin
      chk($sformatf("d%0d freq v%0d", d, v), 32'(f[16*v +: 16]),
          32'({m_reg[d][v][1], m_reg[d][v][0]}));
      chk($sformatf("d%0d duration v%0d", d, v), 32'(du[8*v +: 8]), 32'(m_reg[d][v][2]));
      chk($sformatf("d%0d attack v%0d", d, v),   32'(at[8*v +: 8]), 32'(m_reg[d][v][4]));
      chk($sformatf("d%0d sustain v%0d", d, v),  32'(su[8*v +: 8]), 32'(m_reg[d][v][5]));
      chk($sformatf("d%0d waveform v%0d", d, v), 32'(wf[8*v +: 8]), 32'(m_reg[d][v][6]));
    end
    chk($sformatf("d%0d mix_out", d), 32'(mx), 32'(m_mix[d]));
    chk($sformatf("d%0d sample_valid", d), 32'(sv), 32'(m_valid[d]));
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_dut(0, 128'(f0), 64'(du0), 64'(at0), 64'(su0), 64'(wf0), mx0, sv0);
      check_dut(1, 128'(f1), 64'(du1), 64'(at1), 64'(su1), 64'(wf1), mx1, sv1);
      check_dut(2, 128'(f2), 64'(du2), 64'(at2), 64'(su2), 64'(wf2), mx2, sv2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] v, input logic [7:0] dat);
    reg_addr  = a;
    voice_sel = v;
    wr_data   = dat;
    wr_en     = 1'b1;
    tick(1);
    wr_en = 1'b0;
    tick(1);
  endtask

  function automatic logic get_valid(input int d);
    return (d == 0) ? sv0 : (d == 1) ? sv1 : sv2;
  endfunction

  task automatic wait_valid(input int d, input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!get_valid(d) && waited < budget);
    if (!get_valid(d)) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout d%0d: no sample_valid within %0d cycles", d, budget);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    rst = 1'b1; wr_en = 1'b0; reg_addr = '0; voice_sel = '0; wr_data = '0; voice_in = '0;
    check_en = 1'b0;
    tick(3);
    check_en = 1'b1;
    @(negedge clk);
    chk("reset mix_out", 32'(mx0), 32'h0);
    chk("reset sample_valid", 32'(sv0), 32'h0);
    chk("reset frequency", f0[31:0], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // held strobe writes once; later data change while held is ignored
    reg_addr = 3'd0; voice_sel = 2'd1; wr_data = 8'h34; wr_en = 1'b1;
    tick(5);
    @(negedge clk);
    chk("held write v1 freq", 32'(f0[31:16]), 32'h0034);
    wr_data = 8'h99;
    tick(2);
    @(negedge clk);
    chk("no rewrite while held", 32'(f0[31:16]), 32'h0034);
    wr_en = 1'b0;
    tick(1);

    // voice-2 frequency, and an out-of-range voice for the 3-voice configuration
    wr(3'd1, 2'd2, 8'h12);
    wr(3'd0, 2'd2, 8'h34);
    wr(3'd6, 2'd3, 8'h41);
    @(negedge clk);
    chk("d0 v2 freq", 32'(f0[47:32]), 32'h1234);
    chk("d2 v2 freq", 32'(f2[47:32]), 32'h1234);
    chk("d2 ignores voice 3", 32'(wf2), 32'h0);
    chk("d0 v3 waveform", 32'(wf0[31:24]), 32'h41);

    // all voices full scale at reset gain
    voice_in = 32'hFFFF_FFFF;
    wait_valid(0, 600, w);
    wait_valid(0, 600, w);
    chk("d0 sample period", 32'(w), 32'd255);
    chk("d0 mix full scale", 32'(mx0), 32'hFF);
    wait_valid(1, 20, w);
    wait_valid(1, 20, w);
    chk("d1 mix saturates", 32'(mx1), 32'hFF);
    wait_valid(2, 20, w);
    wait_valid(2, 20, w);
    chk("d2 mix saturates", 32'(mx2), 32'hFF);

    // mute voices 1..3 (ctrl bits 7:1 ignored), voice 0 at 0x80
    wr(3'd7, 2'd1, 8'h01);
    wr(3'd7, 2'd2, 8'h01);
    wr(3'd7, 2'd3, 8'hFF);
    voice_in = 32'hFFFF_FF80;
    wait_valid(1, 20, w);
    wait_valid(1, 20, w);
    chk("d1 muted mix", 32'(mx1), 32'h80);
    wait_valid(2, 20, w);
    wait_valid(2, 20, w);
    chk("d2 muted mix", 32'(mx2), 32'h80);
    wait_valid(0, 600, w);
    wait_valid(0, 600, w);
    chk("d0 muted mix", 32'(mx0), 32'h20);

    // half gain on voice 0
    wr(3'd3, 2'd0, 8'h7F);
    voice_in = 32'h0000_00C8;
    wait_valid(1, 20, w);
    wait_valid(1, 20, w);
    chk("d1 half gain", 32'(mx1), 32'h64);
    wait_valid(0, 600, w);
    wait_valid(0, 600, w);
    chk("d0 half gain", 32'(mx0), 32'h19);

    // reset in the middle of a d0 scan
    w = 0;
    while ((m_cnt[0] % 255) != 2 && w < 600) begin
      @(negedge clk);
      w++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid-scan reset mix_out", 32'(mx0), 32'h0);
    chk("mid-scan reset valid", 32'(sv0), 32'h0);
    w = 0;
    while (!sv0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("first valid after reset", 32'(w), 32'd4);
    chk("mix after reset", 32'(mx0), 32'h32);
    wait_valid(1, 20, w);
    wait_valid(1, 20, w);
    chk("d1 mix after reset", 32'(mx1), 32'hC8);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
